// File: rtl/arm_pkg.sv
// Shared instruction-word layout and types for the ARM fetch path.
package arm_pkg;
    localparam int INSTR_W   = 32;
    localparam int COND_LSB  = 28;
    localparam int COND_W    = 4;
    localparam int OP_LSB    = 26;
    localparam int OP_W      = 2;
    localparam int FUNCT_LSB = 20;
    localparam int FUNCT_W   = 6;
    localparam int RD_LSB    = 12;
    localparam int RD_W      = 4;

    typedef logic [INSTR_W-1:0] word_t;

    localparam word_t RESET_VECTOR_DFLT = 32'h0000_0000;
endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO with a head that is visible combinationally.
// Flush wins over a push in the same cycle.
module instr_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [W-1:0]           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !reset) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches and
// buffers returned words with their PC for the decoder.
module fetch_unit
    import arm_pkg::*;
#(
    parameter int    DEPTH        = 2,
    parameter word_t RESET_VECTOR = RESET_VECTOR_DFLT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [INSTR_W-1:0]   imem_addr,
    input  logic                 imem_resp_valid,
    input  logic [INSTR_W-1:0]   imem_resp_data,
    input  logic                 stall,
    input  logic                 pc_src,
    input  logic [INSTR_W-1:0]   branch_target,
    output logic                 instr_valid,
    output logic [INSTR_W-1:0]   instr,
    output logic [INSTR_W-1:0]   pc_plus8,
    output logic [OP_W-1:0]      op,
    output logic [COND_W-1:0]    cond,
    output logic [FUNCT_W-1:0]   funct,
    output logic [RD_W-1:0]      rd
);
    localparam int CW = $clog2(DEPTH) + 1;

    word_t         r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;
    word_t         r_hold_instr;
    word_t         r_hold_pc8;

    logic              w_credit;
    logic              w_hs;
    logic              w_resp_keep;
    logic              w_push;
    logic              w_pop;
    word_t             w_af_head;
    logic              w_af_full;
    logic              w_af_empty;
    logic [CW-1:0]     w_af_count;
    logic [2*INSTR_W-1:0] w_iq_head;
    logic              w_iq_full;
    logic              w_iq_empty;
    logic [CW-1:0]     w_iq_count;
    word_t             w_q_pc8;
    word_t             w_head_instr;
    word_t             w_head_pc8;

    // Credits cover queued words plus live fetches, so a returning word always has a slot.
    assign w_credit       = ({1'b0, w_iq_count} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
    assign imem_req_valid = !reset && !pc_src && w_credit;
    assign imem_addr      = r_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;
    assign w_resp_keep    = imem_resp_valid && (r_drop == '0);
    assign w_push         = w_resp_keep && !pc_src;
    assign instr_valid    = !reset && !w_iq_empty;
    assign w_pop          = instr_valid && !stall && !pc_src;

    instr_queue #(.DEPTH(DEPTH), .W(INSTR_W)) u_addr_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_hs),
        .i_push_data (r_pc),
        .i_pop       (w_resp_keep),
        .i_flush     (pc_src),
        .o_head      (w_af_head),
        .o_full      (w_af_full),
        .o_empty     (w_af_empty),
        .o_count     (w_af_count)
    );

    instr_queue #(.DEPTH(DEPTH), .W(2*INSTR_W)) u_instr_queue (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data ({w_af_head, imem_resp_data}),
        .i_pop       (w_pop),
        .i_flush     (pc_src),
        .o_head      (w_iq_head),
        .o_full      (w_iq_full),
        .o_empty     (w_iq_empty),
        .o_count     (w_iq_count)
    );

    // A redirect turns everything still outstanding into responses to discard.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_VECTOR;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (pc_src) begin
            r_pc       <= {branch_target[INSTR_W-1:2], 2'b00};
            r_inflight <= '0;
            r_drop     <= r_drop + r_inflight - CW'(imem_resp_valid);
        end else begin
            if (w_hs) r_pc <= r_pc + 32'd4;
            r_inflight <= r_inflight + CW'(w_hs) - CW'(w_resp_keep);
            if (imem_resp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
        end
    end

    assign w_q_pc8 = w_iq_head[2*INSTR_W-1:INSTR_W] + 32'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_instr <= '0;
            r_hold_pc8   <= '0;
        end else if (instr_valid) begin
            r_hold_instr <= w_iq_head[INSTR_W-1:0];
            r_hold_pc8   <= w_q_pc8;
        end
    end

    always_comb begin
        w_head_instr = r_hold_instr;
        w_head_pc8   = r_hold_pc8;
        if (reset) begin
            w_head_instr = '0;
            w_head_pc8   = '0;
        end else if (!w_iq_empty) begin
            w_head_instr = w_iq_head[INSTR_W-1:0];
            w_head_pc8   = w_q_pc8;
        end
    end

    assign instr    = w_head_instr;
    assign pc_plus8 = w_head_pc8;
    assign cond     = w_head_instr[COND_LSB +: COND_W];
    assign op       = w_head_instr[OP_LSB +: OP_W];
    assign funct    = w_head_instr[FUNCT_LSB +: FUNCT_W];
    assign rd       = w_head_instr[RD_LSB +: RD_W];

    a_resp_expected: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> ((r_drop != '0) || !w_af_empty));
    a_push_room: assert property (@(posedge clk) disable iff (reset)
        w_push |-> !w_iq_full);
    a_addr_room: assert property (@(posedge clk) disable iff (reset)
        w_hs |-> !w_af_full);
    a_addr_track: assert property (@(posedge clk) disable iff (reset)
        w_af_count == r_inflight);
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the fetch stream.
module tb_fetch_unit;
    import arm_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_plus8;
    logic [1:0]  op;
    logic [3:0]  cond;
    logic [5:0]  funct;
    logic [3:0]  rd;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(DEPTH), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall           (stall),
        .pc_src          (pc_src),
        .branch_target   (branch_target),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .pc_plus8        (pc_plus8),
        .op              (op),
        .cond            (cond),
        .funct           (funct),
        .rd              (rd)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned gen;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0] pc8;
        logic [31:0] word;
    } ent_t;

    req_t        pend[$];
    ent_t        q[$];
    ent_t        last;
    logic [31:0] exp_pc;
    int unsigned gen;
    int unsigned cyc;
    int unsigned last_due;
    int          lat;
    int          n_checks;
    int          n_fail;

    logic        d_reset, d_stall, d_ready, d_pc_src;
    logic [31:0] d_bt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE081_2003 ^ (a * 32'h9E37_79B1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_cycle();
        int          live;
        bit          exp_req;
        bit          exp_iv;
        bit          keep;
        ent_t        hd;
        req_t        r;
        int unsigned due;
        if (reset) begin
            check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
            check_val("rst_instr_valid", 32'(instr_valid), 32'd0);
            check_val("rst_instr", instr, 32'd0);
            check_val("rst_pc_plus8", pc_plus8, 32'd0);
            check_val("rst_fields", 32'({op, cond, funct, rd}), 32'd0);
            pend.delete();
            q.delete();
            last     = '{pc8: 32'h0, word: 32'h0};
            exp_pc   = 32'h0;
            gen++;
            last_due = cyc;
            return;
        end
        live = 0;
        foreach (pend[i]) if (pend[i].gen == gen) live++;
        exp_req = !pc_src && ((q.size() + live) < DEPTH);
        check_val("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req) check_val("imem_addr", imem_addr, exp_pc);
        exp_iv = (q.size() > 0);
        check_val("instr_valid", 32'(instr_valid), 32'(exp_iv));
        hd = exp_iv ? q[0] : last;
        check_val("instr", instr, hd.word);
        check_val("pc_plus8", pc_plus8, hd.pc8);
        check_val("fields", 32'({op, cond, funct, rd}),
                  32'({hd.word[27:26], hd.word[31:28], hd.word[25:20], hd.word[15:12]}));
        last = hd;

        keep = 1'b0;
        if (imem_resp_valid) begin
            r    = pend.pop_front();
            keep = (r.gen == gen) && !pc_src;
        end
        if (pc_src) begin
            q.delete();
            exp_pc = {branch_target[31:2], 2'b00};
            gen++;
        end else begin
            if (exp_iv && !stall) q.delete(0);
            if (keep) q.push_back('{pc8: r.addr + 32'd8, word: mem_word(r.addr)});
            if (exp_req && imem_req_ready) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: exp_pc, gen: gen, due: due});
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        reset          = d_reset;
        stall          = d_stall;
        imem_req_ready = d_ready;
        pc_src         = d_pc_src;
        branch_target  = d_bt;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        model_cycle();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            step();
            n++;
        end
        check_val(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        d_reset  = 1'b1;
        d_pc_src = 1'b0;
        repeat (cycles) step();
        d_reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        gen      = 0;
        last_due = 0;
        lat      = 1;
        exp_pc   = 32'h0;
        last     = '{pc8: 32'h0, word: 32'h0};
        reset = 1'b1; stall = 1'b0; imem_req_ready = 1'b1; pc_src = 1'b0;
        branch_target = 32'h0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        d_stall = 1'b0; d_ready = 1'b1; d_pc_src = 1'b0; d_bt = 32'h0;

        // streaming from reset vector, 1-cycle memory
        do_reset(3);
        step(); check_val("t1_addr0", imem_addr, 32'h0);
        step(); check_val("t1_addr1", imem_addr, 32'h4);
        step();
        check_val("t1_valid", 32'(instr_valid), 32'd1);
        check_val("t1_pc8_0", pc_plus8, 32'd8);
        check_val("t1_instr", instr, 32'hE081_2003);
        check_val("t1_cond", 32'(cond), 32'hE);
        check_val("t1_op", 32'(op), 32'h0);
        check_val("t1_funct", 32'(funct), 32'h08);
        check_val("t1_rd", 32'(rd), 32'h2);
        step(); check_val("t1_pc8_1", pc_plus8, 32'd12);

        // stall fills the queue, release drains it
        d_stall = 1'b1;
        repeat (6) step();
        check_val("t2_full_noreq", 32'(imem_req_valid), 32'd0);
        check_val("t2_full_valid", 32'(instr_valid), 32'd1);
        d_stall = 1'b0;
        repeat (10) step();

        // request held while not ready
        d_pc_src = 1'b1; d_bt = 32'h0000_0043; d_ready = 1'b0;
        step();
        d_pc_src = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t3_hold_addr", imem_addr, 32'h40);
            check_val("t3_hold_valid", 32'(imem_req_valid), 32'd1);
        end
        d_ready = 1'b1;
        step();
        step(); check_val("t3_next_addr", imem_addr, 32'h44);

        // redirect with two fetches in flight
        lat = 2;
        do_reset(2);
        step(); step();
        d_pc_src = 1'b1; d_bt = 32'h100;
        step();
        d_pc_src = 1'b0;
        step();
        wait_valid("t4_wait");
        check_val("t4_pc8", pc_plus8, 32'h108);
        check_val("t4_instr", instr, mem_word(32'h100));

        // redirect on a response+pop cycle, then a second redirect
        do_reset(2);
        step(); step(); step();
        d_pc_src = 1'b1; d_bt = 32'h200;
        step();
        check_val("t5_head_at_redirect", 32'(instr_valid), 32'd1);
        d_bt = 32'h300;
        step();
        check_val("t5_empty", 32'(instr_valid), 32'd0);
        check_val("t5_noreq", 32'(imem_req_valid), 32'd0);
        d_pc_src = 1'b0;
        step();
        wait_valid("t5_wait");
        check_val("t5_pc8", pc_plus8, 32'h308);
        check_val("t5_instr", instr, mem_word(32'h300));

        // reset with a full queue
        lat = 1;
        d_stall = 1'b1;
        repeat (8) step();
        check_val("t6_full_valid", 32'(instr_valid), 32'd1);
        d_reset = 1'b1;
        step();
        d_reset = 1'b0;
        step();
        check_val("t6_valid", 32'(instr_valid), 32'd0);
        check_val("t6_addr", imem_addr, 32'h0);
        check_val("t6_req", 32'(imem_req_valid), 32'd1);

        // wrap-around at the top of the address space
        d_stall = 1'b0;
        d_pc_src = 1'b1; d_bt = 32'hFFFF_FFFB;
        step();
        d_pc_src = 1'b0;
        step(); check_val("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step(); check_val("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        repeat (12) step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 2);
            d_stall  = ($urandom_range(0, 99) < 40);
            d_ready  = ($urandom_range(0, 99) < 75);
            d_pc_src = ($urandom_range(0, 99) < 6);
            d_bt     = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
            d_reset  = ($urandom_range(0, 999) < 3);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
